// File: rtl/prog_clkdiv.sv
// rtl/prog_clkdiv.sv - runtime-programmable clock-enable divider with one-shot mode and shadowed divisor reload
module prog_clkdiv #(
    parameter int              WIDTH   = 14,
    parameter logic [WIDTH-1:0] DIV_RST = '1,
    parameter int              TC_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             oneshot,
    input  logic             start,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clkdiv,
    output logic             sq_out,
    output logic             busy,
    output logic [TC_W-1:0]  ticks
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] shadow;
    logic             pend;
    logic             tick;

    assign tick   = busy & en & (cnt == div_act);
    assign clkdiv = tick;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            div_act <= DIV_RST;
            shadow  <= DIV_RST;
            pend    <= 1'b0;
            sq_out  <= 1'b0;
            busy    <= 1'b0;
            ticks   <= '0;
        end else begin
            if (busy & en) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end

            if (tick) begin
                sq_out <= ~sq_out;
                ticks  <= ticks + 1'b1;
            end

            // Divisor only changes at a period boundary (or while idle, when cnt is 0),
            // so the running period is never truncated.
            if (div_load && tick) begin
                div_act <= div_in;
                shadow  <= div_in;
                pend    <= 1'b0;
            end else if (div_load && busy) begin
                shadow  <= div_in;
                pend    <= 1'b1;
            end else if (div_load) begin
                div_act <= div_in;
                shadow  <= div_in;
            end else if (tick && pend) begin
                div_act <= shadow;
                pend    <= 1'b0;
            end

            if (!oneshot) begin
                busy <= 1'b1;
            end else if (tick) begin
                busy <= 1'b0;
            end else if (start && !busy) begin
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_clkdiv.sv
// tb/tb_prog_clkdiv.sv - self-checking bench for prog_clkdiv (WIDTH=4, TC_W=2)
module tb_prog_clkdiv;

    localparam int W    = 4;
    localparam int TCW  = 2;
    localparam int DRST = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           oneshot;
    logic           start;
    logic [W-1:0]   div_in;
    logic           div_load;
    logic           clkdiv;
    logic           sq_out;
    logic           busy;
    logic [TCW-1:0] ticks;

    int checks = 0;
    int fails  = 0;

    prog_clkdiv #(.WIDTH(W), .DIV_RST(4'd15), .TC_W(TCW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .oneshot  (oneshot),
        .start    (start),
        .div_in   (div_in),
        .div_load (div_load),
        .clkdiv   (clkdiv),
        .sq_out   (sq_out),
        .busy     (busy),
        .ticks    (ticks)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a countdown of enabled busy cycles left until the next tick, plus a
    // running tick total from which sq_out and ticks follow by parity / modulo.
    bit armed = 0;
    bit m_busy, m_pend, m_tick, m_nbusy;
    int m_rem, m_div, m_shadow, m_total;

    always @(negedge clk) begin
        m_tick = m_busy && en && (m_rem == 0);
        if (armed) begin
            chk("clkdiv", {31'd0, clkdiv}, {31'd0, m_tick});
            chk("sq_out", {31'd0, sq_out}, m_total % 2);
            chk("busy",   {31'd0, busy},   {31'd0, m_busy});
            chk("ticks",  {30'd0, ticks},  m_total % 4);
        end
        if (!rst) begin
            armed    = 1;
            m_busy   = 0;
            m_pend   = 0;
            m_div    = DRST;
            m_shadow = DRST;
            m_rem    = DRST;
            m_total  = 0;
        end else begin
            if (m_tick) m_total++;
            if (div_load && m_tick) begin
                m_div = int'(div_in); m_shadow = int'(div_in); m_pend = 0;
            end else if (div_load && m_busy) begin
                m_shadow = int'(div_in); m_pend = 1;
            end else if (div_load) begin
                m_div = int'(div_in); m_shadow = int'(div_in);
            end else if (m_tick && m_pend) begin
                m_div = m_shadow; m_pend = 0;
            end
            if (m_tick) m_rem = m_div;
            else if (m_busy && en) m_rem--;
            if (!oneshot) m_nbusy = 1;
            else if (m_tick) m_nbusy = 0;
            else if (start && !m_busy) m_nbusy = 1;
            else m_nbusy = m_busy;
            m_busy = m_nbusy;
            if (!m_busy) m_rem = m_div;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic next_tick(output int n);
        bit got;
        got = 0;
        n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (clkdiv === 1'b1) got = 1;
        end
        if (!got) n = -1;
    endtask

    int n;
    int cnt_t;
    int seq [5] = '{1, 2, 3, 0, 1};

    initial begin
        rst = 0; en = 1; oneshot = 0; start = 0; div_load = 0; div_in = '0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_clkdiv", {31'd0, clkdiv}, 0);
        chk("rst_sq",     {31'd0, sq_out}, 0);
        chk("rst_busy",   {31'd0, busy},   0);
        chk("rst_ticks",  {30'd0, ticks},  0);

        // continuous, default divisor 15
        cyc(); rst = 1;
        next_tick(n); chk("first_tick_latency", n, 17);
        next_tick(n); chk("period16", n, 16);
        chk("sq_after_one_tick", {31'd0, sq_out}, 1);

        // reload 3 at cnt=5: current period completes, then period 4
        repeat (6) cyc();
        div_in = 4'd3; div_load = 1;
        cyc(); div_load = 0;
        next_tick(n); chk("reload_no_truncate", n, 10);
        next_tick(n); chk("period4_a", n, 4);
        next_tick(n); chk("period4_b", n, 4);

        // reload 0: tick every cycle
        cyc(); div_in = 4'd0; div_load = 1;
        cyc(); div_load = 0;
        next_tick(n); chk("reload0_boundary", n, 3);
        next_tick(n); chk("div0_every_cycle", n, 1);
        cnt_t = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(); en = (i % 2 == 1);
            @(negedge clk);
            if (clkdiv === 1'b1) cnt_t++;
        end
        chk("en_gated_ticks", cnt_t, 4);
        cyc(); en = 1;

        // one-shot with divisor 7
        oneshot = 1;
        cyc(); cyc();
        @(negedge clk); chk("oneshot_idle", {31'd0, busy}, 0);
        cyc(); div_in = 4'd7; div_load = 1;
        cyc(); div_load = 0; start = 1;
        @(negedge clk); chk("oneshot_no_early", {31'd0, clkdiv}, 0);
        cyc(); start = 0;
        next_tick(n); chk("oneshot_latency", n, 8);
        cyc();
        @(negedge clk); chk("oneshot_done_busy", {31'd0, busy}, 0);
        cyc(); start = 1;
        cyc(); start = 0;
        repeat (3) cyc();
        start = 1;
        cyc(); start = 0;
        cnt_t = 0;
        repeat (20) begin
            @(negedge clk);
            if (clkdiv === 1'b1) cnt_t++;
        end
        chk("restart_ignored", cnt_t, 1);

        // back to continuous, pending reload, reset mid-period
        cyc(); oneshot = 0;
        cyc(); cyc();
        div_in = 4'd2; div_load = 1;
        cyc(); div_load = 0;
        cyc(); rst = 0;
        cyc();
        @(negedge clk);
        chk("midrst_clkdiv", {31'd0, clkdiv}, 0);
        chk("midrst_sq",     {31'd0, sq_out}, 0);
        chk("midrst_busy",   {31'd0, busy},   0);
        chk("midrst_ticks",  {30'd0, ticks},  0);
        cyc(); rst = 1;
        next_tick(n); chk("pend_discarded", n, 17);
        cyc(); chk("tick_seq0", {30'd0, ticks}, seq[0]);
        for (int i = 1; i < 5; i++) begin
            next_tick(n);
            cyc();
            chk("tick_seq", {30'd0, ticks}, seq[i]);
        end

        // switch to one-shot at cnt=2
        cyc(); cyc(); oneshot = 1;
        next_tick(n); chk("switch_last_tick", n, 14);
        cnt_t = 0;
        repeat (40) begin
            @(negedge clk);
            if (clkdiv === 1'b1) cnt_t++;
        end
        chk("switch_no_more_ticks", cnt_t, 0);
        chk("switch_idle", {31'd0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
